cp_id_stage_fwd: RTL

- Parametrised second-generation RV32I decode stage. It sits between IF and EX, under the same valid/ready pipeline discipline.
- Adds the following over the first-generation decoder:
  - optional input skid buffer (registered ready toward IF);
  - full sign-extended immediate generation;
  - EX/WB operand forwarding;
  - load-use interlock (bubble insertion);
  - synchronous flush;
  - illegal-opcode flagging.
- The ID→EX pipeline register lives here.

---
 rtl/cp_pkg.sv | 48 ++++
 rtl/cp_skid_buffer.sv | 38 +++
 rtl/cp_id_stage_fwd.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cp_pkg.sv
// Shared RV32I decode constants, byte-enable encodings and the ID->EX register payload.
// Pure declarations; no timing or flow-control behaviour of its own.
package cp_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [6:0] opcode;
        logic       rd_we;
        logic       dmem_we;
        logic [3:0] ld_be;
        logic [3:0] st_be;
        logic       illegal;
    } id_ex_t;

    function automatic logic [3:0] be_of_f3(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return BE_B;
            F3_H, F3_HU: return BE_H;
            F3_W:        return BE_W;
            default:     return BE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cp_skid_buffer.sv
// One-entry skid: parks a beat that arrived but was not taken downstream the same cycle.
// Zero latency when empty; in_rdy is the inverted full flop, so upstream stalls one cycle after a park.
module cp_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    logic         full;
    logic [W-1:0] skid_dat;

    assign in_rdy  = ~full;
    assign out_vld = full | in_vld;
    assign out_dat = full ? skid_dat : in_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (full) begin
            if (out_rdy) full <= 1'b0;
        end else if (in_vld && !out_rdy) begin
            full     <= 1'b1;
            skid_dat <= in_dat;
        end
    end

endmodule

// File: rtl/cp_id_stage_fwd.sv
// RV32I decode with immediates, EX/WB forwarding, load-use interlock and the ID->EX register.
// One cycle IF->EX; a load-use hit inserts a bubble and holds the source, EX stall holds everything.
module cp_id_stage_fwd
    import cp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SKID_EN = 1,
    parameter int FWD_EN  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_data_if_i,
    input  logic            instr_valid_if_i,
    output logic            instr_ready_if_o,
    input  logic            flush_i,
    input  logic            ready_ex_i,
    output logic            valid_ex_o,
    output logic [XLEN-1:0] rs1_data_ex_o,
    output logic [XLEN-1:0] rs2_data_ex_o,
    output logic [4:0]      rd_addr_ex_o,
    output logic [2:0]      func3_ex_o,
    output logic [6:0]      func7_ex_o,
    output logic [6:0]      opcode_ex_o,
    output logic [XLEN-1:0] imm_ex_o,
    output logic            rd_we_ex_o,
    output logic            dmem_we_ex_o,
    output logic [3:0]      ld_be_ex_o,
    output logic [3:0]      st_be_ex_o,
    output logic            illegal_ex_o,
    output logic [4:0]      rs1_addr_rf_o,
    output logic [4:0]      rs2_addr_rf_o,
    input  logic [XLEN-1:0] rs1_data_rf_i,
    input  logic [XLEN-1:0] rs2_data_rf_i,
    input  logic            ex_fwd_valid_i,
    input  logic [4:0]      ex_fwd_addr_i,
    input  logic [XLEN-1:0] ex_fwd_data_i,
    input  logic            wb_fwd_valid_i,
    input  logic [4:0]      wb_fwd_addr_i,
    input  logic [XLEN-1:0] wb_fwd_data_i
);

    logic [31:0]     src_instr;
    logic            src_valid;
    logic            cke;
    logic            hazard;
    logic            consume;
    id_ex_t          dec;
    id_ex_t          ex_q;
    logic            valid_q;
    logic [31:0]     imm32;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            rs1_used, rs2_used;
    logic [4:0]      rs1, rs2;

    assign cke     = ~valid_q | ready_ex_i;
    assign consume = cke & src_valid & ~hazard;

    generate
        if (SKID_EN != 0) begin : g_skid
            cp_skid_buffer #(.W(32)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush_i),
                .in_vld  (instr_valid_if_i),
                .in_dat  (instr_data_if_i),
                .in_rdy  (instr_ready_if_o),
                .out_vld (src_valid),
                .out_dat (src_instr),
                .out_rdy (consume)
            );
        end else begin : g_no_skid
            assign src_valid        = instr_valid_if_i;
            assign src_instr        = instr_data_if_i;
            assign instr_ready_if_o = cke & ~hazard;
        end
    endgenerate

    assign rs1           = src_instr[19:15];
    assign rs2           = src_instr[24:20];
    assign rs1_addr_rf_o = rs1;
    assign rs2_addr_rf_o = rs2;

    always_comb begin
        dec         = '0;
        imm32       = '0;
        rs1_used    = 1'b1;
        rs2_used    = 1'b0;
        dec.opcode  = src_instr[6:0];
        dec.rd      = src_instr[11:7];
        dec.func3   = src_instr[14:12];
        dec.func7   = src_instr[31:25];
        case (src_instr[6:0])
            OP: begin
                dec.rd_we = 1'b1;
                rs2_used  = 1'b1;
            end
            OP_IMM, JALR: begin
                dec.rd_we = 1'b1;
                imm32     = {{20{src_instr[31]}}, src_instr[31:20]};
            end
            LOAD: begin
                dec.rd_we = 1'b1;
                dec.ld_be = be_of_f3(src_instr[14:12]);
                imm32     = {{20{src_instr[31]}}, src_instr[31:20]};
            end
            STORE: begin
                dec.dmem_we = 1'b1;
                dec.st_be   = be_of_f3(src_instr[14:12]);
                rs2_used    = 1'b1;
                imm32       = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
            end
            BRANCH: begin
                rs2_used = 1'b1;
                imm32    = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                            src_instr[30:25], src_instr[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                dec.rd_we = 1'b1;
                rs1_used  = 1'b0;
                imm32     = {src_instr[31:12], 12'b0};
            end
            JAL: begin
                dec.rd_we = 1'b1;
                rs1_used  = 1'b0;
                imm32     = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                             src_instr[20], src_instr[30:21], 1'b0};
            end
            SYSTEM: begin
                imm32 = {{20{src_instr[31]}}, src_instr[31:20]};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_dat,
        input logic            exv,
        input logic [4:0]      exa,
        input logic [XLEN-1:0] exd,
        input logic            wbv,
        input logic [4:0]      wba,
        input logic [XLEN-1:0] wbd
    );
        logic [XLEN-1:0] r;
        r = rf_dat;
        if (FWD_EN != 0) begin
            if (addr == 5'd0)                  r = '0;
            else if (exv && (exa == addr))     r = exd;
            else if (wbv && (wba == addr))     r = wbd;
        end
        return r;
    endfunction

    assign rs1_fwd = resolve(rs1, rs1_data_rf_i, ex_fwd_valid_i, ex_fwd_addr_i, ex_fwd_data_i,
                             wb_fwd_valid_i, wb_fwd_addr_i, wb_fwd_data_i);
    assign rs2_fwd = resolve(rs2, rs2_data_rf_i, ex_fwd_valid_i, ex_fwd_addr_i, ex_fwd_data_i,
                             wb_fwd_valid_i, wb_fwd_addr_i, wb_fwd_data_i);

    // Without forwarding, any producer still in EX or WB must retire before a dependent issues.
    logic ex_live, ex_hit, wb_hit;
    assign ex_live = valid_q & ex_q.rd_we & (ex_q.rd != 5'd0);
    assign ex_hit  = (rs1_used & (rs1 == ex_q.rd)) | (rs2_used & (rs2 == ex_q.rd));
    assign wb_hit  = wb_fwd_valid_i & (wb_fwd_addr_i != 5'd0) &
                     ((rs1_used & (rs1 == wb_fwd_addr_i)) | (rs2_used & (rs2 == wb_fwd_addr_i)));
    assign hazard  = (ex_live & ex_hit & ((ex_q.opcode == LOAD) | (FWD_EN == 0)))
                   | ((FWD_EN == 0) & wb_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
        end else if (flush_i) begin
            valid_q      <= 1'b0;
            ex_q.rd_we   <= 1'b0;
            ex_q.dmem_we <= 1'b0;
        end else if (cke) begin
            if (src_valid && !hazard) begin
                valid_q <= 1'b1;
                ex_q    <= dec;
                rs1_q   <= rs1_fwd;
                rs2_q   <= rs2_fwd;
                imm_q   <= XLEN'($signed(imm32));
            end else begin
                valid_q      <= 1'b0;
                ex_q.rd_we   <= 1'b0;
                ex_q.dmem_we <= 1'b0;
            end
        end
    end

    assign valid_ex_o    = valid_q;
    assign rs1_data_ex_o = rs1_q;
    assign rs2_data_ex_o = rs2_q;
    assign imm_ex_o      = imm_q;
    assign rd_addr_ex_o  = ex_q.rd;
    assign func3_ex_o    = ex_q.func3;
    assign func7_ex_o    = ex_q.func7;
    assign opcode_ex_o   = ex_q.opcode;
    assign rd_we_ex_o    = ex_q.rd_we;
    assign dmem_we_ex_o  = ex_q.dmem_we;
    assign ld_be_ex_o    = ex_q.ld_be;
    assign st_be_ex_o    = ex_q.st_be;
    assign illegal_ex_o  = ex_q.illegal;

endmodule
